sc_fetch_decode: RTL and testbench

SC_FETCH_DECODE -- requirements
Module: sc_fetch_decode

---
 rtl/sc_fetch_decode.sv | 144 ++++++++++++++
 tb/tb_sc_fetch_decode.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_fetch_decode.sv
// Fetch/decode front end: PLL-gated fetch FSM, PC, instruction register, decode.
// Ports: clk/reset, pllLocked, imem req/addr/rdata/valid, next-PC select, decoded fields, lock, instrCount.
module sc_fetch_decode #(
    parameter int               DBITS               = 32,
    parameter int               OP_BIT_WIDTH        = 4,
    parameter int               REG_INDEX_BIT_WIDTH = 4,
    parameter int               IMEM_ADDR_BITS      = 11,
    parameter logic [DBITS-1:0] START_PC            = 'h40
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           pllLocked,

    output logic                           imemReq,
    output logic [IMEM_ADDR_BITS-1:0]      imemAddr,
    input  logic [31:0]                    imemRdata,
    input  logic                           imemValid,

    input  logic                           useImmPc,
    input  logic                           isJal,
    input  logic [DBITS-1:0]               pcIn,

    output logic                           lock,
    output logic [DBITS-1:0]               pcOut,
    output logic [DBITS-1:0]               pcAdded,
    output logic [OP_BIT_WIDTH-1:0]        op1,
    output logic [OP_BIT_WIDTH-1:0]        op2,
    output logic [REG_INDEX_BIT_WIDTH-1:0] rd,
    output logic [REG_INDEX_BIT_WIDTH-1:0] rs1,
    output logic [REG_INDEX_BIT_WIDTH-1:0] rs2,
    output logic [DBITS-1:0]               imm32,
    output logic [31:0]                    instrCount
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        FETCH     = 2'd1,
        EXEC      = 2'd2
    } state_t;

    localparam int OP2_TOP = 31 - OP_BIT_WIDTH;
    localparam int RD_TOP  = 31 - 2 * OP_BIT_WIDTH;
    localparam int RS1_TOP = RD_TOP - REG_INDEX_BIT_WIDTH;
    localparam int RS2_TOP = RS1_TOP - REG_INDEX_BIT_WIDTH;

    state_t           state;
    logic [31:0]      instrReg;
    logic [DBITS-1:0] nextPc;
    logic [DBITS-1:0] immSext;
    logic [15:0]      imm16;
    logic             isBranch;

    // Jump targets are word aligned; the low two bits of pcIn are dropped.
    logic unusedPcInLow;
    assign unusedPcInLow = ^pcIn[1:0];

    assign pcAdded  = pcOut + DBITS'(4);
    assign imemAddr = pcOut[IMEM_ADDR_BITS+1:2];

    always_comb begin
        nextPc = pcAdded;
        if (isJal || useImmPc) begin
            nextPc = {pcIn[DBITS-1:2], 2'b00};
        end
    end

    // Sequencer: lock and imemReq are registered alongside the state so
    // they always describe the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= WAIT_LOCK;
            pcOut      <= START_PC;
            instrReg   <= '0;
            instrCount <= '0;
            lock       <= 1'b0;
            imemReq    <= 1'b0;
        end else begin
            unique case (state)
                WAIT_LOCK: begin
                    lock <= 1'b0;
                    if (pllLocked) begin
                        state   <= FETCH;
                        imemReq <= 1'b1;
                    end else begin
                        imemReq <= 1'b0;
                    end
                end
                FETCH: begin
                    if (!pllLocked) begin
                        // Abandon the fetch; PC is untouched so relock refetches it.
                        state   <= WAIT_LOCK;
                        imemReq <= 1'b0;
                        lock    <= 1'b0;
                    end else if (imemValid) begin
                        instrReg <= imemRdata;
                        state    <= EXEC;
                        imemReq  <= 1'b0;
                        lock     <= 1'b1;
                    end else begin
                        imemReq <= 1'b1;
                        lock    <= 1'b0;
                    end
                end
                EXEC: begin
                    // The execute cycle always retires, even if lock is lost.
                    pcOut      <= nextPc;
                    instrCount <= instrCount + 32'd1;
                    lock       <= 1'b0;
                    if (pllLocked) begin
                        state   <= FETCH;
                        imemReq <= 1'b1;
                    end else begin
                        state   <= WAIT_LOCK;
                        imemReq <= 1'b0;
                    end
                end
                default: begin
                    state   <= WAIT_LOCK;
                    imemReq <= 1'b0;
                    lock    <= 1'b0;
                end
            endcase
        end
    end

    assign op1   = instrReg[31 -: OP_BIT_WIDTH];
    assign op2   = instrReg[OP2_TOP -: OP_BIT_WIDTH];
    assign rd    = instrReg[RD_TOP -: REG_INDEX_BIT_WIDTH];
    assign rs1   = instrReg[RS1_TOP -: REG_INDEX_BIT_WIDTH];
    assign rs2   = instrReg[RS2_TOP -: REG_INDEX_BIT_WIDTH];
    assign imm16 = instrReg[15:0];

    assign immSext  = {{(DBITS-16){imm16[15]}}, imm16};
    assign isBranch = op1[2] && !op1[0];

    // Branches expose their PC-relative target so the controller can feed it back as pcIn.
    always_comb begin
        imm32 = immSext;
        if (isBranch) begin
            imm32 = pcAdded + (immSext << 2);
        end
    end

endmodule

// File: tb/tb_sc_fetch_decode.sv
// Directed bench for sc_fetch_decode: boot, branch, JAL, stall, lock loss, resets, wrap.
module tb_sc_fetch_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic        pllLocked;
    logic        imemReq;
    logic [10:0] imemAddr;
    logic [31:0] imemRdata;
    logic        imemValid;
    logic        useImmPc;
    logic        isJal;
    logic [31:0] pcIn;
    logic        lock;
    logic [31:0] pcOut;
    logic [31:0] pcAdded;
    logic [3:0]  op1;
    logic [3:0]  op2;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [31:0] imm32;
    logic [31:0] instrCount;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sc_fetch_decode dut (
        .clk        (clk),
        .reset      (reset),
        .pllLocked  (pllLocked),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .imemRdata  (imemRdata),
        .imemValid  (imemValid),
        .useImmPc   (useImmPc),
        .isJal      (isJal),
        .pcIn       (pcIn),
        .lock       (lock),
        .pcOut      (pcOut),
        .pcAdded    (pcAdded),
        .op1        (op1),
        .op2        (op2),
        .rd         (rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .imm32      (imm32),
        .instrCount (instrCount)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present an instruction for one FETCH cycle; leaves the DUT in EXEC.
    task automatic fetchIn(input logic [31:0] instr);
        imemRdata = instr;
        imemValid = 1'b1;
        step();
        imemValid = 1'b0;
    endtask

    // Finish the EXEC cycle with the given next-PC selection.
    task automatic endExec(input logic jal, input logic useImm, input logic [31:0] target);
        isJal    = jal;
        useImmPc = useImm;
        pcIn     = target;
        step();
        isJal    = 1'b0;
        useImmPc = 1'b0;
        pcIn     = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        pllLocked = 1'b0;
        imemRdata = '0;
        imemValid = 1'b0;
        useImmPc  = 1'b0;
        isJal     = 1'b0;
        pcIn      = '0;
        @(negedge clk);
        step();
        reset = 1'b0;

        check("rst_lock", 32'(lock), 32'd0);
        check("rst_req", 32'(imemReq), 32'd0);
        check("rst_pc", pcOut, 32'h40);
        check("rst_pcAdded", pcAdded, 32'h44);
        check("rst_addr", 32'(imemAddr), 32'h10);
        check("rst_op1", 32'(op1), 32'd0);
        check("rst_rd", 32'(rd), 32'd0);
        check("rst_imm", imm32, 32'd0);
        check("rst_cnt", instrCount, 32'd0);

        step();
        step();
        check("waitlock_req", 32'(imemReq), 32'd0);

        // Boot fetch at 0x40.
        pllLocked = 1'b1;
        step();
        check("boot_req", 32'(imemReq), 32'd1);
        check("boot_lock0", 32'(lock), 32'd0);
        fetchIn(32'h8123_0004);
        check("boot_lock", 32'(lock), 32'd1);
        check("boot_req0", 32'(imemReq), 32'd0);
        check("boot_op1", 32'(op1), 32'h8);
        check("boot_op2", 32'(op2), 32'h1);
        check("boot_rd", 32'(rd), 32'h2);
        check("boot_rs1", 32'(rs1), 32'h3);
        check("boot_rs2", 32'(rs2), 32'h0);
        check("boot_imm", imm32, 32'h4);
        check("boot_pc", pcOut, 32'h40);
        // imemValid during EXEC must not reload the instruction register.
        imemRdata = 32'hFFFF_FFFF;
        imemValid = 1'b1;
        endExec(1'b0, 1'b0, 32'h0);
        imemValid = 1'b0;
        check("boot_pcNext", pcOut, 32'h44);
        check("boot_cnt", instrCount, 32'd1);
        check("boot_lockOff", 32'(lock), 32'd0);
        check("ignore_op1", 32'(op1), 32'h8);
        check("refetch_req", 32'(imemReq), 32'd1);

        // Memory stall at 0x44.
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_req", 32'(imemReq), 32'd1);
            check("stall_lock", 32'(lock), 32'd0);
            check("stall_pc", pcOut, 32'h44);
        end

        // JAL at 0x44 to 0x203 -> 0x200.
        fetchIn(32'h3000_0000);
        check("jal_lock", 32'(lock), 32'd1);
        check("jal_pcAdded", pcAdded, 32'h48);
        endExec(1'b1, 1'b0, 32'h0000_0203);
        check("jal_pc", pcOut, 32'h200);
        check("jal_addr", 32'(imemAddr), 32'h80);
        check("hold_op1", 32'(op1), 32'h3);
        check("jal_cnt", instrCount, 32'd2);

        // Jump to 0x100 via useImmPc.
        fetchIn(32'h2000_0010);
        check("nb_imm", imm32, 32'h10);
        endExec(1'b0, 1'b1, 32'h100);
        check("jmp_pc", pcOut, 32'h100);

        // Taken branch at 0x100, imm16=-1: target 0x104-4 = 0x100.
        fetchIn(32'h4000_FFFF);
        check("br_op1", 32'(op1), 32'h4);
        check("br_pcAdded", pcAdded, 32'h104);
        check("br_imm", imm32, 32'h100);
        endExec(1'b0, 1'b1, 32'h100);
        check("br_pc", pcOut, 32'h100);
        check("br_cnt", instrCount, 32'd4);

        // Branch op1=6, imm16=0x10 not taken: imm32 = 0x104 + 0x40.
        fetchIn(32'h6000_0010);
        check("br6_imm", imm32, 32'h144);
        endExec(1'b0, 1'b0, 32'h0);
        check("br6_pc", pcOut, 32'h104);

        // op1=5 has bit0 set: plain sign extension.
        fetchIn(32'h5000_8000);
        check("sext_imm", imm32, 32'hFFFF_8000);
        endExec(1'b0, 1'b0, 32'h0);
        check("sext_pc", pcOut, 32'h108);

        fetchIn(32'h1000_0000);
        endExec(1'b1, 1'b0, 32'h80);
        check("to80_pc", pcOut, 32'h80);
        check("to80_cnt", instrCount, 32'd7);

        // Lock loss during FETCH.
        pllLocked = 1'b0;
        step();
        check("ll_req", 32'(imemReq), 32'd0);
        check("ll_pc", pcOut, 32'h80);
        step();
        check("ll_req2", 32'(imemReq), 32'd0);
        pllLocked = 1'b1;
        step();
        check("relock_req", 32'(imemReq), 32'd1);
        check("relock_addr", 32'(imemAddr), 32'h20);

        // Lock loss during EXEC: retire, then wait.
        fetchIn(32'h1000_0000);
        pllLocked = 1'b0;
        endExec(1'b0, 1'b0, 32'h0);
        check("lle_pc", pcOut, 32'h84);
        check("lle_cnt", instrCount, 32'd8);
        check("lle_req", 32'(imemReq), 32'd0);
        check("lle_lock", 32'(lock), 32'd0);
        step();
        check("lle_req2", 32'(imemReq), 32'd0);
        pllLocked = 1'b1;
        step();
        check("lle_relock", 32'(imemReq), 32'd1);

        // Back to 0x80, then reset mid-EXEC.
        fetchIn(32'h1000_0000);
        endExec(1'b1, 1'b0, 32'h80);
        check("pre_rst_pc", pcOut, 32'h80);
        fetchIn(32'h9ABC_0001);
        check("pre_rst_lock", 32'(lock), 32'd1);
        reset = 1'b1;
        endExec(1'b1, 1'b0, 32'h300);
        reset = 1'b0;
        check("rexec_pc", pcOut, 32'h40);
        check("rexec_cnt", instrCount, 32'd0);
        check("rexec_lock", 32'(lock), 32'd0);
        check("rexec_op1", 32'(op1), 32'd0);

        // Reset during FETCH; late imemValid ignored.
        step();
        check("rf_req", 32'(imemReq), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rf_req0", 32'(imemReq), 32'd0);
        imemRdata = 32'hFFFF_FFFF;
        imemValid = 1'b1;
        step();
        imemValid = 1'b0;
        check("rf_late_op1", 32'(op1), 32'd0);
        check("rf_late_lock", 32'(lock), 32'd0);
        check("rf_req1", 32'(imemReq), 32'd1);

        // PC wrap-around.
        fetchIn(32'h1000_0000);
        endExec(1'b1, 1'b0, 32'hFFFF_FFFF);
        check("wrap_pc", pcOut, 32'hFFFF_FFFC);
        check("wrap_pcAdded", pcAdded, 32'h0);
        fetchIn(32'h1000_0000);
        endExec(1'b0, 1'b0, 32'h0);
        check("wrap_pc0", pcOut, 32'h0);
        check("wrap_cnt", instrCount, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
